// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs shared by the host arbiter and its
// round-robin picker, the arbiter state enum, and the priority-pick helper.
//   tl_h2d_t : host-to-device (A channel request fields plus d_ready)
//   tl_d2h_t : device-to-host (D channel response fields plus a_ready)
//   rr_pick  : first set request bit at or above a pointer, modulo m
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    // The picker works on a fixed 8-wide view so one function serves every M.
    localparam int RrMaxHosts = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Walk from the highest offset down so the lowest offset from ptr wins.
    function automatic rr_pick_t rr_pick(input logic [RrMaxHosts-1:0] req,
                                         input logic [2:0] ptr,
                                         input int m);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = RrMaxHosts - 1; i >= 0; i--) begin
            if (i < m) begin
                k = (int'(ptr) + i) % m;
                if (req[k]) begin
                    r.valid = 1'b1;
                    r.idx   = 3'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tlul_rr_pick.sv
// tlul_rr_pick: combinational round-robin picker.
//   req_i   : one request bit per host
//   ptr_i   : host index with highest priority
//   idx_o   : chosen host (0 when nothing is requested)
//   valid_o : at least one request present
module tlul_rr_pick
    import tlul_pkg::*;
#(
    parameter  int M  = 2,
    localparam int IW = $clog2(M)
) (
    input  logic [M-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [RrMaxHosts-1:0] req_ext;
    rr_pick_t              pick;

    always_comb begin
        req_ext        = '0;
        req_ext[M-1:0] = req_i;
        pick           = rr_pick(req_ext, 3'(ptr_i), M);
        idx_o          = IW'(pick.idx);
        valid_o        = pick.valid;
    end

endmodule

// File: rtl/tlul_host_arb.sv
// tlul_host_arb: round-robin TL-UL arbiter sharing one device port among M
// hosts. A grant is held until every A beat issued under it is answered;
// outstanding beats and beats per grant are capped so no host starves.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tl_h_i/tl_h_o  : per-host request / response
//   tl_d_o/tl_d_i  : device request / response
//   owner_o        : current grant, or the host that would be granted next
//   busy_o         : grant held
//   err_spurious_o : D beat arrived with nothing outstanding (dropped)
module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter  int M              = 2,
    parameter  int MaxOutstanding = 2,
    parameter  int MaxBurst       = 4,
    localparam int IW             = $clog2(M),
    localparam int OW             = $clog2(MaxOutstanding + 1),
    localparam int BW             = $clog2(MaxBurst + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t [M-1:0]      tl_h_i,
    output tl_d2h_t [M-1:0]      tl_h_o,
    output tl_h2d_t              tl_d_o,
    input  tl_d2h_t              tl_d_i,
    output logic [IW-1:0]        owner_o,
    output logic                 busy_o,
    output logic                 err_spurious_o
);

    localparam logic [OW-1:0] OutMax   = OW'(MaxOutstanding);
    localparam logic [BW-1:0] BurstMax = BW'(MaxBurst);
    localparam logic [IW-1:0] LastHost = IW'(M - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] out_q, out_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          pend_vld_q, pend_vld_d;
    logic [IW-1:0] pend_idx_q, pend_idx_d;

    logic [M-1:0]  req;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] cand, sel;
    logic          cand_vld, a_fwd, a_hs, d_hs;

    always_comb begin
        for (int h = 0; h < M; h++) req[h] = tl_h_i[h].a_valid;
    end

    tlul_rr_pick #(.M(M)) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        out_d          = out_q;
        burst_d        = burst_q;
        pend_vld_d     = 1'b0;
        pend_idx_d     = pend_idx_q;
        owner_o        = owner_q;
        busy_o         = 1'b0;
        err_spurious_o = 1'b0;

        // A host stalled on a_ready keeps the candidate slot even if a
        // higher-priority host starts requesting meanwhile.
        cand     = pend_vld_q ? pend_idx_q : pick_idx;
        cand_vld = pend_vld_q | pick_vld;

        if (state_q == IDLE) begin
            sel     = cand;
            a_fwd   = cand_vld;
            owner_o = cand_vld ? cand : rr_ptr_q;
        end else begin
            sel    = owner_q;
            a_fwd  = (out_q < OutMax) && (burst_q < BurstMax);
            busy_o = 1'b1;
        end

        // A channel: straight through from the selected host.
        tl_d_o         = tl_h_i[sel];
        tl_d_o.a_valid = a_fwd & tl_h_i[sel].a_valid;
        tl_d_o.d_ready = 1'b0;
        for (int h = 0; h < M; h++) begin
            tl_h_o[h]         = tl_d_i;
            tl_h_o[h].d_valid = 1'b0;
            tl_h_o[h].a_ready = 1'b0;
        end
        if (a_fwd) tl_h_o[sel].a_ready = tl_d_i.a_ready;
        a_hs = tl_d_o.a_valid & tl_d_i.a_ready;

        // D channel: owner only; beats with nothing outstanding are sunk.
        d_hs = 1'b0;
        if (out_q != '0) begin
            tl_h_o[owner_q].d_valid = tl_d_i.d_valid;
            tl_d_o.d_ready          = tl_h_i[owner_q].d_ready;
            d_hs                    = tl_d_i.d_valid & tl_h_i[owner_q].d_ready;
        end else if (tl_d_i.d_valid) begin
            tl_d_o.d_ready = 1'b1;
            err_spurious_o = 1'b1;
        end

        if (state_q == IDLE) begin
            if (a_hs) begin
                state_d = BUSY;
                owner_d = cand;
                out_d   = OW'(1);
                burst_d = BW'(1);
            end else if (cand_vld && tl_h_i[cand].a_valid) begin
                pend_vld_d = 1'b1;
                pend_idx_d = cand;
            end
        end else begin
            if (a_hs) burst_d = burst_q + BW'(1);
            if (a_hs && !d_hs)      out_d = out_q + OW'(1);
            else if (d_hs && !a_hs) out_d = out_q - OW'(1);
            // Last answer drained: give the next host first pick.
            if (d_hs && !a_hs && out_q == OW'(1)) begin
                state_d  = IDLE;
                rr_ptr_d = (owner_q == LastHost) ? '0 : owner_q + IW'(1);
                burst_d  = '0;
            end
        end

        // Quiet port while reset is held.
        if (rst_i) begin
            tl_d_o         = '0;
            tl_h_o         = '0;
            owner_o        = '0;
            busy_o         = 1'b0;
            err_spurious_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            out_q      <= '0;
            burst_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            out_q      <= out_d;
            burst_q    <= burst_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    // Counters must never wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == BUSY) begin
            assert (!(a_hs && !d_hs && out_q == OutMax));
            assert (!(d_hs && !a_hs && out_q == '0));
            assert (!(a_hs && burst_q == BurstMax));
        end
    end

endmodule
